// File: rtl/rr_grant_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg
// Shared definitions for the round-robin grant arbiter:
//   - state_e : arbiter FSM states (IDLE, GRANT, GAP)
//   - DEF_N_REQ / DEF_TIMEOUT : default requester count and grant time limit
//   - clog2() : index width for a given requester count
// ---------------------------------------------------------------------------
package arb_pkg;

  localparam int DEF_N_REQ   = 4;
  localparam int DEF_TIMEOUT = 200;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_e;

  // Smallest r with 2**r >= n; used to size requester indices.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_grant_arbiter_if.sv
// ---------------------------------------------------------------------------
// rr_grant_arbiter_if
// Request/grant bundle between the requesting agents and the arbiter.
//   req       : request vector, bit i = requester i
//   done      : current owner finished
//   grant     : registered one-hot grant (zero when no owner)
//   grant_vld : grant is nonzero
//   grant_id  : index of current owner (0 when none)
//   busy      : arbiter not idle
//   timeout   : one-cycle pulse on forced release
// Modports: master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface rr_grant_arbiter_if
  import arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ
);
  localparam int ID_W = clog2(N_REQ);

  logic [N_REQ-1:0] req;
  logic             done;
  logic [N_REQ-1:0] grant;
  logic             grant_vld;
  logic [ID_W-1:0]  grant_id;
  logic             busy;
  logic             timeout;

  modport master (
    output req,
    output done,
    input  grant,
    input  grant_vld,
    input  grant_id,
    input  busy,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output grant,
    output grant_vld,
    output grant_id,
    output busy,
    output timeout
  );

endinterface

// File: rtl/rr_grant_arbiter_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin winner selection: finds the first set bit of
// req searching ptr, ptr+1, ..., N_REQ-1, 0, ..., ptr-1.
//   req    in  N_REQ  request vector
//   ptr    in  ID_W   highest-priority index
//   winner out ID_W   index of the selected requester (0 when none)
//   found  out 1      at least one request is set
// ---------------------------------------------------------------------------
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [ID_W-1:0]  winner,
  output logic             found
);

  // Rotate req right by ptr so that bit k of rot_req is requester (ptr+k).
  logic [2*N_REQ-1:0] dbl_req;
  logic [2*N_REQ-1:0] shifted;
  logic [N_REQ-1:0]   rot_req;
  logic [ID_W-1:0]    cand_idx [N_REQ];

  assign dbl_req = {req, req};
  assign shifted = dbl_req >> ptr;
  assign rot_req = shifted[N_REQ-1:0];
  assign found   = |rot_req;

  // Absolute requester index for each rotated position, wrapped to N_REQ.
  // One spare bit holds ptr+k before the wrap (max 2*N_REQ-2).
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
      logic [ID_W:0] sum;
      assign sum = {1'b0, ptr} + (ID_W+1)'(gi);
      assign cand_idx[gi] = (sum >= (ID_W+1)'(N_REQ)) ?
                            ID_W'(sum - (ID_W+1)'(N_REQ)) : ID_W'(sum);
    end
  endgenerate

  // Priority encode: scanning downward lets the lowest rotated slot win.
  always_comb begin
    winner = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot_req[k]) winner = cand_idx[k];
    end
  end

endmodule

// File: rtl/rr_grant_arbiter.sv
// ---------------------------------------------------------------------------
// rr_grant_arbiter
// Sequential round-robin arbiter sharing one resource among N_REQ agents.
// A registered one-hot grant is held until the owner raises done or drops
// its request; priority then rotates to the next index and one all-zero
// GAP cycle is inserted so the resource select is break-before-make.
//
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : rr_grant_arbiter_if.slave (req, done in; grant, grant_vld,
//          grant_id, busy, timeout out)
//
// Build option: define ARB_TIMEOUT_EN to force release after a grant has
// been held TIMEOUT cycles (timeout pulses in the first GAP cycle).
// Without it timeout is tied low and a grant may be held indefinitely.
// ---------------------------------------------------------------------------
module rr_grant_arbiter
  import arb_pkg::*;
#(
  parameter int N_REQ   = DEF_N_REQ,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int TO_W    = 8
) (
  input logic               clk,
  input logic               rst,
  rr_grant_arbiter_if.slave bus
);

  localparam int ID_W = clog2(N_REQ);

  generate
    if (N_REQ < 2 || N_REQ > 16) begin : g_bad_n_req
      $error("rr_grant_arbiter: N_REQ must be in 2..16");
    end
    if (TIMEOUT < 1 || (64'd1 << TO_W) <= 64'(TIMEOUT)) begin : g_bad_to_w
      $error("rr_grant_arbiter: need TIMEOUT >= 1 and 2**TO_W > TIMEOUT");
    end
  endgenerate

  state_e           state_reg;
  logic [ID_W-1:0]  ptr_reg;
  logic [N_REQ-1:0] grant_reg;
  logic [ID_W-1:0]  grant_id_reg;

  logic [ID_W-1:0]  pick_winner;
  logic             pick_found;
  logic             owner_release;
  logic             release_next;
  logic [ID_W-1:0]  ptr_next;

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .req    (bus.req),
    .ptr    (ptr_reg),
    .winner (pick_winner),
    .found  (pick_found)
  );

  // done and abort together are a single release.
  assign owner_release = bus.done || !bus.req[grant_id_reg];

  assign ptr_next = (grant_id_reg == ID_W'(N_REQ - 1)) ? '0
                                                      : grant_id_reg + 1'b1;

`ifdef ARB_TIMEOUT_EN
  logic [TO_W-1:0] cnt_reg;
  logic            timeout_reg;
  logic            expire;

  // Expiry is only "forced" when the owner did not release that same cycle.
  assign expire       = (cnt_reg == TO_W'(TIMEOUT - 1)) && !owner_release;
  assign release_next = owner_release || expire;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg     <= '0;
      timeout_reg <= 1'b0;
    end else begin
      timeout_reg <= 1'b0;
      if (state_reg == IDLE) begin
        cnt_reg <= '0;
      end else if (state_reg == GRANT) begin
        if (release_next) begin
          timeout_reg <= expire;
          cnt_reg     <= '0;
        end else begin
          cnt_reg <= cnt_reg + TO_W'(1);
        end
      end
    end
  end

  assign bus.timeout = timeout_reg;
`else
  assign release_next = owner_release;
  assign bus.timeout  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      ptr_reg      <= '0;
      grant_reg    <= '0;
      grant_id_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pick_found) begin
            grant_reg    <= N_REQ'(1) << pick_winner;
            grant_id_reg <= pick_winner;
            state_reg    <= GRANT;
          end
        end
        GRANT: begin
          if (release_next) begin
            grant_reg    <= '0;
            grant_id_reg <= '0;
            ptr_reg      <= ptr_next;
            state_reg    <= GAP;
          end
        end
        GAP: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg    <= IDLE;
          grant_reg    <= '0;
          grant_id_reg <= '0;
        end
      endcase
    end
  end

  assign bus.grant     = grant_reg;
  assign bus.grant_vld = |grant_reg;
  assign bus.grant_id  = grant_id_reg;
  assign bus.busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_grant_arbiter
// Vector table of {rst, req, done} -> expected outputs after the next edge,
// followed by hand-written timeout / long-hold sequences. Expectations are
// queued when inputs are driven and popped once the edge has produced them.
// ---------------------------------------------------------------------------
module tb_rr_grant_arbiter;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  rr_grant_arbiter_if #(.N_REQ(N)) bus ();

  rr_grant_arbiter #(
    .N_REQ   (N),
    .TIMEOUT (5),
    .TO_W    (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] grant;
    logic [1:0] id;
    logic       busy;
    logic       to;
    string      name;
  } vec_t;

  typedef struct {
    logic [8:0] obs;
    string      name;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  function automatic vec_t mk(input logic r, input logic [3:0] rq, input logic d,
                              input logic [3:0] g, input logic [1:0] id,
                              input logic b, input logic t, input string nm);
    vec_t v;
    v.rst = r; v.req = rq; v.done = d;
    v.grant = g; v.id = id; v.busy = b; v.to = t; v.name = nm;
    return v;
  endfunction

  task automatic add(input logic r, input logic [3:0] rq, input logic d,
                     input logic [3:0] g, input logic [1:0] id,
                     input logic b, input logic t, input string nm);
    vecs.push_back(mk(r, rq, d, g, id, b, t, nm));
  endtask

  // Pop the oldest expectation and compare against the current outputs.
  task automatic check_out();
    exp_t       e;
    logic [8:0] act;
    total_cnt++;
    if (sb.size() == 0) begin
      $display("FAIL scoreboard_empty: got no expectation, required one queued");
      return;
    end
    e   = sb.pop_front();
    act = {bus.grant, bus.grant_vld, bus.grant_id, bus.busy, bus.timeout};
    if (act === e.obs) begin
      pass_cnt++;
      $display("ok   %-16s grant=%b vld=%b id=%0d busy=%b to=%b",
               e.name, act[8:5], act[4], act[3:2], act[1], act[0]);
    end else begin
      $display("FAIL %-16s got grant=%b vld=%b id=%0d busy=%b to=%b, required grant=%b vld=%b id=%0d busy=%b to=%b",
               e.name, act[8:5], act[4], act[3:2], act[1], act[0],
               e.obs[8:5], e.obs[4], e.obs[3:2], e.obs[1], e.obs[0]);
    end
  endtask

  // Drive inputs, queue the expected post-edge outputs, advance one edge.
  task automatic apply(input vec_t v);
    exp_t e;
    rst      = v.rst;
    bus.req  = v.req;
    bus.done = v.done;
    e.obs    = {v.grant, |v.grant, v.id, v.busy, v.to};
    e.name   = v.name;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    rst      = 1'b1;
    bus.req  = '0;
    bus.done = 1'b0;

    //   rst  req      done grant    id  busy to
    add(1, 4'b1111, 0, 4'b0000, 0, 0, 0, "reset0");
    add(1, 4'b1111, 0, 4'b0000, 0, 0, 0, "reset1");
    add(1, 4'b1111, 0, 4'b0000, 0, 0, 0, "reset2");
    add(0, 4'b1111, 0, 4'b0001, 0, 1, 0, "first_grant0");
    add(0, 4'b1111, 0, 4'b0001, 0, 1, 0, "rot_hold0");
    add(0, 4'b1111, 1, 4'b0000, 0, 1, 0, "rot_gap0");
    add(0, 4'b1111, 0, 4'b0000, 0, 0, 0, "rot_idle0");
    add(0, 4'b1111, 0, 4'b0010, 1, 1, 0, "rot_grant1");
    add(0, 4'b1111, 0, 4'b0010, 1, 1, 0, "rot_hold1");
    add(0, 4'b1111, 1, 4'b0000, 0, 1, 0, "rot_gap1");
    add(0, 4'b1111, 0, 4'b0000, 0, 0, 0, "rot_idle1");
    add(0, 4'b1111, 0, 4'b0100, 2, 1, 0, "rot_grant2");
    add(0, 4'b1111, 0, 4'b0100, 2, 1, 0, "rot_hold2");
    add(0, 4'b1111, 1, 4'b0000, 0, 1, 0, "rot_gap2");
    add(0, 4'b1111, 0, 4'b0000, 0, 0, 0, "rot_idle2");
    add(0, 4'b1111, 0, 4'b1000, 3, 1, 0, "rot_grant3");
    add(0, 4'b1111, 0, 4'b1000, 3, 1, 0, "rot_hold3");
    add(0, 4'b1111, 1, 4'b0000, 0, 1, 0, "rot_gap3");
    add(0, 4'b1111, 0, 4'b0000, 0, 0, 0, "rot_idle3");
    add(0, 4'b1111, 0, 4'b0001, 0, 1, 0, "rot_wrap0");
    add(0, 4'b1111, 1, 4'b0000, 0, 1, 0, "rot_gap_w");
    add(0, 4'b0100, 0, 4'b0000, 0, 0, 0, "pre_idle");
    add(0, 4'b0100, 0, 4'b0100, 2, 1, 0, "pre_grant2");
    add(0, 4'b0100, 1, 4'b0000, 0, 1, 0, "pre_gap_ptr3");
    add(0, 4'b0101, 0, 4'b0000, 0, 0, 0, "skip_idle");
    add(0, 4'b0101, 0, 4'b0001, 0, 1, 0, "skip_wrap_id0");
    add(0, 4'b0101, 1, 4'b0000, 0, 1, 0, "skip_gap_ptr1");
    add(0, 4'b0101, 0, 4'b0000, 0, 0, 0, "skip_idle2");
    add(0, 4'b0101, 0, 4'b0100, 2, 1, 0, "skip_id2");
    add(0, 4'b0001, 0, 4'b0000, 0, 1, 0, "abort_clear");
    add(0, 4'b0000, 0, 4'b0000, 0, 0, 0, "abort_idle");
    add(0, 4'b0000, 0, 4'b0000, 0, 0, 0, "idle_noreq");
    add(0, 4'b1001, 0, 4'b1000, 3, 1, 0, "abort_ptr3");
    add(0, 4'b1001, 1, 4'b0000, 0, 1, 0, "late_gap");
    add(0, 4'b0010, 0, 4'b0000, 0, 0, 0, "late_req_in_gap");
    add(0, 4'b0010, 0, 4'b0010, 1, 1, 0, "late_grant1");
    add(0, 4'b0010, 1, 4'b0000, 0, 1, 0, "late_rel_ptr2");
    add(0, 4'b0000, 1, 4'b0000, 0, 0, 0, "done_in_gap");
    add(0, 4'b0000, 1, 4'b0000, 0, 0, 0, "done_in_idle");
    add(0, 4'b1001, 0, 4'b1000, 3, 1, 0, "ptr_kept2");
    add(0, 4'b0001, 1, 4'b0000, 0, 1, 0, "done_and_abort");
    add(0, 4'b0000, 0, 4'b0000, 0, 0, 0, "dna_idle");
    add(0, 4'b0001, 0, 4'b0001, 0, 1, 0, "rst_pre_grant");
    add(0, 4'b0001, 1, 4'b0000, 0, 1, 0, "rst_pre_ptr1");
    add(0, 4'b0100, 0, 4'b0000, 0, 0, 0, "rst_pre_idle");
    add(0, 4'b0100, 0, 4'b0100, 2, 1, 0, "rst_pre_id2");
    add(1, 4'b0011, 0, 4'b0000, 0, 0, 0, "rst_mid_grant");
    add(0, 4'b0011, 0, 4'b0001, 0, 1, 0, "rst_ptr0");
    add(0, 4'b0011, 1, 4'b0000, 0, 1, 0, "rst_after_rel");
    add(0, 4'b0000, 0, 4'b0000, 0, 0, 0, "rst_after_idle");

    foreach (vecs[i]) apply(vecs[i]);

`ifdef ARB_TIMEOUT_EN
    // Forced release after 5 held cycles, pulse in first GAP cycle.
    apply(mk(0, 4'b0001, 0, 4'b0001, 0, 1, 0, "to_cycle1"));
    for (int c = 2; c <= 5; c++)
      apply(mk(0, 4'b0001, 0, 4'b0001, 0, 1, 0, "to_hold"));
    apply(mk(0, 4'b0001, 0, 4'b0000, 0, 1, 1, "to_pulse"));
    apply(mk(0, 4'b0001, 0, 4'b0000, 0, 0, 0, "to_pulse_end"));
    // Done on the expiry cycle is a normal release.
    apply(mk(0, 4'b0001, 0, 4'b0001, 0, 1, 0, "tod_cycle1"));
    for (int c = 2; c <= 5; c++)
      apply(mk(0, 4'b0001, 0, 4'b0001, 0, 1, 0, "tod_hold"));
    apply(mk(0, 4'b0001, 1, 4'b0000, 0, 1, 0, "tod_done_expiry"));
    apply(mk(0, 4'b0000, 0, 4'b0000, 0, 0, 0, "tod_idle"));
`else
    // Without the timeout option a grant is held as long as the owner wants.
    apply(mk(0, 4'b0001, 0, 4'b0001, 0, 1, 0, "long_cycle1"));
    for (int c = 2; c <= 12; c++)
      apply(mk(0, 4'b0001, 0, 4'b0001, 0, 1, 0, "long_hold"));
    apply(mk(0, 4'b0001, 1, 4'b0000, 0, 1, 0, "long_release"));
    apply(mk(0, 4'b0000, 0, 4'b0000, 0, 0, 0, "long_idle"));
`endif

    if (sb.size() != 0) begin
      total_cnt++;
      $display("FAIL scoreboard_leftover: got %0d queued, required 0", sb.size());
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
